// File: rtl/rtc_timekeeper.sv
// Real-time-clock core: prescales clk to a one-second tick and keeps hh:mm:ss,
// a wrapping day count, a range-checked load, an hh:mm alarm and a 12-hour view.
module rtc_timekeeper #(
  parameter int CLK_DIV = 50_000_000,
  parameter int DAY_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [5:0]       ss_in,
  input  logic [5:0]       mm_in,
  input  logic [5:0]       hh_in,
  input  logic             alarm_wr,
  input  logic [5:0]       al_mm_in,
  input  logic [5:0]       al_hh_in,
  input  logic             alarm_en,
  input  logic             alarm_clr,
  output logic [5:0]       ss,
  output logic [5:0]       mm,
  output logic [5:0]       hh,
  output logic [3:0]       hh12,
  output logic             pm,
  output logic [DAY_W-1:0] day_cnt,
  output logic             sec_tick,
  output logic             day_tick,
  output logic             alarm_flag,
  output logic             load_err
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0]    presc_reg;
  logic [5:0]       ss_reg, mm_reg, hh_reg;
  logic [5:0]       al_mm_reg, al_hh_reg;
  logic [DAY_W-1:0] day_reg;
  logic             sec_tick_reg, day_tick_reg, alarm_flag_reg, load_err_reg;

  // Range checks: fields 0..2 are the time load, 3..4 the alarm write.
  logic [5:0] fld_in [5];
  logic [4:0] fld_ok;

  assign fld_in[0] = ss_in;
  assign fld_in[1] = mm_in;
  assign fld_in[2] = hh_in;
  assign fld_in[3] = al_mm_in;
  assign fld_in[4] = al_hh_in;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_range
      localparam logic [5:0] LIM = (gi == 2 || gi == 4) ? 6'd24 : 6'd60;
      assign fld_ok[gi] = (fld_in[gi] < LIM);
    end
  endgenerate

  logic load_ok, alarm_ok, load_take, alarm_take, inc, inc_take;

  assign load_ok    = &fld_ok[2:0];
  assign alarm_ok   = &fld_ok[4:3];
  assign load_take  = load && load_ok;
  assign alarm_take = alarm_wr && alarm_ok;
  assign inc        = run && (presc_reg == PW'(CLK_DIV - 1));
  // A valid load overrides a coinciding increment entirely.
  assign inc_take   = inc && !load_take;

  logic       ss_wrap, mm_wrap, hh_wrap, midnight, alarm_hit;
  logic [5:0] ss_next, mm_next, hh_next;

  assign ss_wrap  = (ss_reg == 6'd59);
  assign mm_wrap  = (mm_reg == 6'd59);
  assign hh_wrap  = (hh_reg == 6'd23);
  assign midnight = ss_wrap && mm_wrap && hh_wrap;

  assign ss_next = ss_wrap ? 6'd0 : ss_reg + 6'd1;
  assign mm_next = ss_wrap ? (mm_wrap ? 6'd0 : mm_reg + 6'd1) : mm_reg;
  assign hh_next = (ss_wrap && mm_wrap) ? (hh_wrap ? 6'd0 : hh_reg + 6'd1) : hh_reg;

  // ss_next is zero exactly when seconds wrap.
  assign alarm_hit = alarm_en && ss_wrap && (mm_next == al_mm_reg) && (hh_next == al_hh_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg      <= '0;
      ss_reg         <= '0;
      mm_reg         <= '0;
      hh_reg         <= '0;
      al_mm_reg      <= '0;
      al_hh_reg      <= '0;
      day_reg        <= '0;
      sec_tick_reg   <= 1'b0;
      day_tick_reg   <= 1'b0;
      alarm_flag_reg <= 1'b0;
      load_err_reg   <= 1'b0;
    end else begin
      if (load_take) begin
        presc_reg <= '0;
      end else if (run) begin
        presc_reg <= inc ? '0 : presc_reg + PW'(1);
      end

      if (load_take) begin
        ss_reg <= ss_in;
        mm_reg <= mm_in;
        hh_reg <= hh_in;
      end else if (inc_take) begin
        ss_reg <= ss_next;
        mm_reg <= mm_next;
        hh_reg <= hh_next;
      end

      if (inc_take && midnight) begin
        day_reg <= day_reg + DAY_W'(1);
      end

      sec_tick_reg <= inc_take;
      day_tick_reg <= inc_take && midnight;

      if (inc_take && alarm_hit) begin
        alarm_flag_reg <= 1'b1;
      end else if (alarm_clr) begin
        alarm_flag_reg <= 1'b0;
      end

      if (alarm_take) begin
        al_mm_reg <= al_mm_in;
        al_hh_reg <= al_hh_in;
      end

      if (load || alarm_wr) begin
        load_err_reg <= (load && !load_ok) || (alarm_wr && !alarm_ok);
      end
    end
  end

  logic [5:0] hh_m12;
  logic [3:0] hh12_next;

  assign hh_m12 = hh_reg - 6'd12;

  always_comb begin
    hh12_next = hh_reg[3:0];
    if (hh_reg == 6'd0) begin
      hh12_next = 4'd12;
    end else if (hh_reg > 6'd12) begin
      hh12_next = hh_m12[3:0];
    end
  end

  assign ss         = ss_reg;
  assign mm         = mm_reg;
  assign hh         = hh_reg;
  assign hh12       = hh12_next;
  assign pm         = (hh_reg >= 6'd12);
  assign day_cnt    = day_reg;
  assign sec_tick   = sec_tick_reg;
  assign day_tick   = day_tick_reg;
  assign alarm_flag = alarm_flag_reg;
  assign load_err   = load_err_reg;

endmodule
